// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - stall/flush/redirect sequencing around ID-resolved branches, with saturating perf counters
module branch_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_rn,
    input  logic [4:0]           id_rm,
    input  logic                 id_uses_rm,
    input  logic                 id_is_branch,
    input  logic                 id_br_reg,
    input  logic                 BrTaken,
    input  logic                 UncondBr,
    input  logic                 pc_rd,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 mem_is_load,
    input  logic [4:0]           mem_rd,
    output logic                 pc_wr_en,
    output logic                 ifid_wr_en,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 redirect,
    output logic                 in_flush,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]           SQ_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [4:0]           XZR     = 5'd31;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] sq_cnt;
    logic [2:0] sq_cnt_nxt;

    logic in_run;
    logic luse;
    logic bhaz;
    logic stall;
    logic taken;
    logic br_ev;
    logic tk_ev;

    // X31 reads as zero, so a compare against it never signals a hazard
    always_comb begin
        in_run = (state == RUN);
        luse   = ex_is_load && (ex_rd != XZR) &&
                 ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        bhaz   = id_br_reg && mem_is_load && (mem_rd != XZR) && (mem_rd == id_rn);
        stall  = id_valid && in_run && (luse || bhaz);
        taken  = id_valid && id_is_branch && (BrTaken || UncondBr || pc_rd);
        br_ev  = id_valid && id_is_branch && in_run && !stall;
        tk_ev  = br_ev && taken;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            sq_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sq_cnt_nxt  = sq_cnt;
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        redirect    = 1'b0;
        in_flush    = 1'b0;
        case (state)
            RUN: begin
                // stall outranks resolution so a branch never uses a stale operand
                if (stall) begin
                    pc_wr_en    = 1'b0;
                    ifid_wr_en  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (taken) begin
                    redirect   = 1'b1;
                    ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt  = FLUSH;
                        sq_cnt_nxt = SQ_INIT;
                    end
                end
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                in_flush    = 1'b1;
                sq_cnt_nxt  = sq_cnt - 3'd1;
                if (sq_cnt <= 3'd1) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt  = RUN;
                sq_cnt_nxt = 3'd0;
            end
        endcase
        // outputs follow reset immediately, not at the next edge
        if (!reset_n) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            redirect    = 1'b0;
            in_flush    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (br_ev && (br_cnt != CNT_MAX)) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (tk_ev && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - table-driven and sequence checks for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

    // ctl bit order: {pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, redirect, in_flush}
    localparam logic [5:0] NRM = 6'b110000;
    localparam logic [5:0] STL = 6'b000100;
    localparam logic [5:0] TKN = 6'b111010;
    localparam logic [5:0] FLS = 6'b111101;
    localparam logic [5:0] RST = 6'b001100;

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urm;
        logic       isb;
        logic       brr;
        logic       bt;
        logic       ub;
        logic       pcr;
        logic       exl;
        logic [4:0] exrd;
        logic       meml;
        logic [4:0] memrd;
        logic [5:0] ctl;
        logic       ebr;
        logic       etk;
        logic       est;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid, id_uses_rm, id_is_branch, id_br_reg;
    logic [4:0] id_rn, id_rm, ex_rd, mem_rd;
    logic       BrTaken, UncondBr, pc_rd, ex_is_load, mem_is_load;

    wire [5:0]  ctl_a, ctl_b, ctl_c, ctl_d;
    wire [31:0] br_a, tk_a, st_a, br_c, tk_c, st_c, br_d, tk_d, st_d;
    wire [3:0]  br_b, tk_b, st_b;

    int n_chk = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_tk = 0;
    int exp_st = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(32)) u_a (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rm(id_uses_rm), .id_is_branch(id_is_branch), .id_br_reg(id_br_reg),
        .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .pc_wr_en(ctl_a[5]), .ifid_wr_en(ctl_a[4]), .ifid_flush(ctl_a[3]),
        .idex_bubble(ctl_a[2]), .redirect(ctl_a[1]), .in_flush(ctl_a[0]),
        .br_cnt(br_a), .taken_cnt(tk_a), .stall_cnt(st_a));

    branch_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rm(id_uses_rm), .id_is_branch(id_is_branch), .id_br_reg(id_br_reg),
        .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .pc_wr_en(ctl_b[5]), .ifid_wr_en(ctl_b[4]), .ifid_flush(ctl_b[3]),
        .idex_bubble(ctl_b[2]), .redirect(ctl_b[1]), .in_flush(ctl_b[0]),
        .br_cnt(br_b), .taken_cnt(tk_b), .stall_cnt(st_b));

    branch_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) u_c (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rm(id_uses_rm), .id_is_branch(id_is_branch), .id_br_reg(id_br_reg),
        .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .pc_wr_en(ctl_c[5]), .ifid_wr_en(ctl_c[4]), .ifid_flush(ctl_c[3]),
        .idex_bubble(ctl_c[2]), .redirect(ctl_c[1]), .in_flush(ctl_c[0]),
        .br_cnt(br_c), .taken_cnt(tk_c), .stall_cnt(st_c));

    branch_hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_WIDTH(32)) u_d (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rm(id_uses_rm), .id_is_branch(id_is_branch), .id_br_reg(id_br_reg),
        .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .pc_wr_en(ctl_d[5]), .ifid_wr_en(ctl_d[4]), .ifid_flush(ctl_d[3]),
        .idex_bubble(ctl_d[2]), .redirect(ctl_d[1]), .in_flush(ctl_d[0]),
        .br_cnt(br_d), .taken_cnt(tk_d), .stall_cnt(st_d));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
        id_is_branch = 1'b0; id_br_reg = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
        pc_rd = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; mem_is_load = 1'b0; mem_rd = 5'd0;
    endtask

    task automatic apply(input vec_t t);
        id_valid = t.v; id_rn = t.rn; id_rm = t.rm; id_uses_rm = t.urm;
        id_is_branch = t.isb; id_br_reg = t.brr; BrTaken = t.bt; UncondBr = t.ub;
        pc_rd = t.pcr; ex_is_load = t.exl; ex_rd = t.exrd; mem_is_load = t.meml; mem_rd = t.memrd;
    endtask

    // inputs change on the falling edge, outputs are sampled 2 time units later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        //                v  rn     rm     urm isb brr bt ub pcr exl exrd   meml memrd  ctl  br tk st
        vecs[0]  = '{1'b0, 5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  NRM, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  STL, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd2,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  STL, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd2,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  NRM, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0,  NRM, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd1,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  STL, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  NRM, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd31, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd31, NRM, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  TKN, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  NRM, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 5'd6,  TKN, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 5'd3,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  NRM, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'd1,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  STL, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  NRM, 1'b0, 1'b0, 1'b0};

        set_idle();
        id_valid = 1'b1; UncondBr = 1'b1; id_is_branch = 1'b1;
        #12;
        chk("reset_ctl", 32'(ctl_a), 32'(RST));
        chk("reset_br_cnt", br_a, 32'd0);
        chk("reset_stall_cnt", st_a, 32'd0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            step();
            apply(vecs[i]);
            #2;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].ctl));
            exp_br += int'(vecs[i].ebr);
            exp_tk += int'(vecs[i].etk);
            exp_st += int'(vecs[i].est);
        end
        step(); set_idle(); #2;
        chk("table_br_cnt", br_a, 32'(exp_br));
        chk("table_taken_cnt", tk_a, 32'(exp_tk));
        chk("table_stall_cnt", st_a, 32'(exp_st));

        // LDUR X1 then ADD X2,X1,X3
        do_reset();
        step(); id_valid = 1'b1; id_rn = 5'd1; id_rm = 5'd3; id_uses_rm = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd1; #2;
        chk("luse_stall", 32'(ctl_a), 32'(STL));
        step(); ex_is_load = 1'b0; ex_rd = 5'd0; #2;
        chk("luse_resume", 32'(ctl_a), 32'(NRM));
        chk("luse_stall_cnt", st_a, 32'd1);

        // LDUR X1 then CBZ X1 (taken)
        do_reset();
        step(); id_valid = 1'b1; id_is_branch = 1'b1; id_br_reg = 1'b1; id_rn = 5'd1;
        ex_is_load = 1'b1; ex_rd = 5'd1; #2;
        chk("cbz_stall1", 32'(ctl_a), 32'(STL));
        step(); ex_is_load = 1'b0; mem_is_load = 1'b1; mem_rd = 5'd1; #2;
        chk("cbz_stall2", 32'(ctl_a), 32'(STL));
        step(); mem_is_load = 1'b0; BrTaken = 1'b1; #2;
        chk("cbz_redirect", 32'(ctl_a), 32'(TKN));
        chk("cbz_stall_cnt", st_a, 32'd2);
        step(); set_idle(); #2;
        chk("cbz_after", 32'(ctl_a), 32'(NRM));
        chk("cbz_br_cnt", br_a, 32'd1);
        chk("cbz_taken_cnt", tk_a, 32'd1);

        // FLUSH_CYCLES=3, B in ID; hazard/branch inputs during FLUSH must be ignored
        do_reset();
        step(); id_valid = 1'b1; id_is_branch = 1'b1; UncondBr = 1'b1; #2;
        chk("fc3_redirect", 32'(ctl_c), 32'(TKN));
        step(); ex_is_load = 1'b1; ex_rd = 5'd0; #2;
        chk("fc3_flush1", 32'(ctl_c), 32'(FLS));
        step(); #2;
        chk("fc3_flush2", 32'(ctl_c), 32'(FLS));
        step(); set_idle(); #2;
        chk("fc3_run", 32'(ctl_c), 32'(NRM));
        chk("fc3_br_cnt", br_c, 32'd1);
        chk("fc3_stall_cnt", st_c, 32'd0);

        // FLUSH_CYCLES=4, reset pulsed in the second FLUSH cycle
        do_reset();
        step(); id_valid = 1'b1; id_is_branch = 1'b1; UncondBr = 1'b1; #2;
        chk("fc4_redirect", 32'(ctl_d), 32'(TKN));
        step(); set_idle(); #2;
        chk("fc4_flush1", 32'(ctl_d), 32'(FLS));
        step(); #2;
        chk("fc4_flush2", 32'(ctl_d), 32'(FLS));
        reset_n = 1'b0; #1;
        chk("fc4_reset_ctl", 32'(ctl_d), 32'(RST));
        chk("fc4_reset_br_cnt", br_d, 32'd0);
        step(); reset_n = 1'b1;
        step(); id_valid = 1'b1; #2;
        chk("fc4_first_run", 32'(ctl_d), 32'(NRM));
        step(); #2;
        chk("fc4_second_run", 32'(ctl_d), 32'(NRM));

        // 20 consecutive taken B: 4-bit counters saturate
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(); id_valid = 1'b1; id_is_branch = 1'b1; UncondBr = 1'b1;
        end
        step(); set_idle(); #2;
        chk("sat_br_cnt", 32'(br_b), 32'd15);
        chk("sat_taken_cnt", 32'(tk_b), 32'd15);
        chk("wide_br_cnt", br_a, 32'd20);
        chk("wide_taken_cnt", tk_a, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
